// File: rtl/piso_serializer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | piso_serializer_pkg: shared state encodings, defaults and helpers.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Counter width for 0..w-1, never below one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/piso_serializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | piso_serializer_if: load handshake plus framed serial output bundle. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface piso_serializer_if
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             serial_out;
  logic             serial_valid;
  logic             frame_done;

  modport master (
    output load_data,
    output load_valid,
    input  load_ready,
    input  serial_out,
    input  serial_valid,
    input  frame_done
  );

  modport slave (
    input  load_data,
    input  load_valid,
    output load_ready,
    output serial_out,
    output serial_valid,
    output frame_done
  );

endinterface
`default_nettype wire

// File: rtl/piso_serializer_tx_bit_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tx_bit_counter: bit position within a frame, flags the last bit.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tx_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic last
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(WIDTH - 1));

endmodule
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | piso_serializer: valid/ready word load, LSB-first serial transmit.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  piso_serializer_if.slave   bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             done_q, done_d;
  logic             last;
  logic             in_shift;
  logic             accept;

  assign in_shift       = (state_q == ST_SHIFT);
  // Ready depends only on state and position, so a new word can land on the last-bit edge.
  assign bus.load_ready = (state_q == ST_IDLE) | (in_shift & last);
  assign accept         = bus.load_valid & bus.load_ready;

  tx_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (accept | (in_shift & last)),
    .enable (in_shift & ~last),
    .last   (last)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_d = bus.load_data;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (last) begin
          done_d = 1'b1;
          if (accept) begin
            shift_d = bus.load_data;
          end else begin
            shift_d = '0;
            state_d = ST_IDLE;
          end
        end else begin
          shift_d = {1'b0, shift_q[WIDTH-1:1]};
        end
      end
    endcase
  end

  assign bus.serial_out   = in_shift & shift_q[0];
  assign bus.serial_valid = in_shift;
  assign bus.frame_done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// Scoreboard bench: a bit-queue reference model predicts every serial bit,
// frame_done and load_ready; a negedge monitor checks them and a SIPO loopback.
module tb_piso_serializer;

  localparam int W = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   armed    = 1'b0;

  piso_serializer_if #(.WIDTH(W)) bus ();

  piso_serializer #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic           rem[$];      // bits still to appear on the line, current first
  logic           exp_q[$];    // scoreboard of expected serial bits
  logic [W-1:0]   word_q[$];   // words whose frame_done is still outstanding
  logic           exp_done  = 1'b0;
  logic           exp_valid = 1'b0;
  logic           exp_out   = 1'b0;
  logic           exp_ready = 1'b1;
  logic [W-1:0]   sipo      = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    if (!reset) begin
      armed = 1'b1;
      rem.delete();
      exp_q.delete();
      word_q.delete();
      exp_done = 1'b0;
    end else begin
      logic ready_now;
      ready_now = (rem.size() <= 1);
      exp_done  = (rem.size() == 1);
      if (rem.size() > 0) void'(rem.pop_front());
      if (bus.load_valid && ready_now) begin
        for (int i = 0; i < W; i++) begin
          rem.push_back(bus.load_data[i]);
          exp_q.push_back(bus.load_data[i]);
        end
        word_q.push_back(bus.load_data);
      end
    end
    exp_valid = (rem.size() > 0);
    exp_out   = (rem.size() > 0) ? rem[0] : 1'b0;
    exp_ready = (rem.size() <= 1);
  end

  always @(negedge clock) begin
    if (armed) begin
      check("serial_valid", 32'(bus.serial_valid), 32'(exp_valid));
      check("load_ready", 32'(bus.load_ready), 32'(exp_ready));
      check("frame_done", 32'(bus.frame_done), 32'(exp_done));
      if (bus.serial_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bit", 32'(1), 32'(0));
        end else begin
          check("serial_bit", 32'(bus.serial_out), 32'(exp_q.pop_front()));
        end
      end else begin
        check("serial_out_idle", 32'(bus.serial_out), 32'(exp_out));
      end
      // Loopback: compare before shifting, since a back-to-back frame's bit0 shares this cycle.
      if (bus.frame_done) begin
        if (word_q.size() == 0) check("spurious_frame_done", 32'(1), 32'(0));
        else check("sipo_word", 32'(sipo), 32'(word_q.pop_front()));
      end
      if (bus.serial_valid) sipo = {bus.serial_out, sipo[W-1:1]};
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d);
    bus.load_valid = v;
    bus.load_data  = d;
  endtask

  initial begin
    drive(1'b1, 4'h9);
    reset = 1'b0;
    cyc(3);
    check("reset_ready", 32'(bus.load_ready), 32'(1));
    check("reset_valid", 32'(bus.serial_valid), 32'(0));
    reset = 1'b1;
    drive(1'b0, '0);
    cyc(2);

    // single frame
    drive(1'b1, 4'b1011);
    cyc(1);
    drive(1'b0, '0);
    cyc(6);

    // back-to-back
    drive(1'b1, 4'hA);
    cyc(1);
    drive(1'b1, 4'h5);
    cyc(4);
    drive(1'b0, '0);
    cyc(6);

    // reset mid-frame then a fresh load
    drive(1'b1, 4'hF);
    cyc(1);
    drive(1'b0, '0);
    cyc(2);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    check("midreset_valid", 32'(bus.serial_valid), 32'(0));
    cyc(1);
    drive(1'b1, 4'h3);
    cyc(1);
    drive(1'b0, '0);
    cyc(6);

    // loads while busy are ignored
    drive(1'b1, 4'h6);
    cyc(1);
    drive(1'b1, 4'h0);
    cyc(3);
    drive(1'b0, '0);
    cyc(6);

    // continuous loopback of every word
    drive(1'b1, 4'h0);
    cyc(1);
    for (int w = 1; w < 16; w++) begin
      drive(1'b1, 4'(w));
      cyc(4);
    end
    drive(1'b0, '0);
    cyc(6);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 3) != 0, 4'($urandom));
      reset = (($urandom % 97) != 0);
      cyc(1);
    end
    reset = 1'b1;
    drive(1'b0, '0);
    cyc(8);

    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    check("words_drained", 32'(word_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
